// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM register-link reader endpoint.
package tdm_pkg;

    localparam int unsigned TDM_DATA_W = 16;

    // Frame phases in which each channel's word is on the link
    localparam logic [1:0] PH_CH0_CAP = 2'd2;
    localparam logic [1:0] PH_CH1_CAP = 2'd0;

    typedef logic [0:0] tdm_ch_t;

    localparam tdm_ch_t CH0 = 1'b0;
    localparam tdm_ch_t CH1 = 1'b1;

endpackage

// File: rtl/tdm_rx_fifo.sv
// Registered first-word-fall-through FIFO for one link channel.
// A push into a full FIFO is only accepted when a pop frees the head slot in the same cycle.
module tdm_rx_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // When full, wr_ptr equals rd_ptr: the new word lands in the slot being popped
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_rx_demux.sv
// Reader endpoint of the 2-channel, 4-phase TDM link: phase recovery, capture, per-channel FIFOs.
// Define RX_PARITY_EN to add even-parity checking of captured words (rx_parity / par_err).
module tdm_rx_demux
    import tdm_pkg::*;
#(
    parameter int unsigned DATA_W     = TDM_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] ch0_data,
    output logic              ch0_valid,
    input  logic              ch0_ready,
    output logic [DATA_W-1:0] ch1_data,
    output logic              ch1_valid,
    input  logic              ch1_ready,
    output logic [1:0]        ovf,
`ifdef RX_PARITY_EN
    input  logic              rx_parity,
    output logic [1:0]        par_err,
`endif
    input  logic              ovf_clr
);

    logic [1:0]        phase_q, phase_d;
    logic              armed_q, armed_d;
    logic [1:0]        ovf_q, ovf_d, ovf_set;
    logic [1:0]        par_q, par_d, par_set;
    logic              cap_hit, par_bad;
    tdm_ch_t           cap_ch;
    logic [1:0]        push, pop, full, empty, ready;
    logic [DATA_W-1:0] head [2];

    assign ready = {ch1_ready, ch0_ready};

`ifdef RX_PARITY_EN
    assign par_bad = ^{rx_data, rx_parity};
    assign par_err = par_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        cap_hit = 1'b0;
        cap_ch  = CH0;
        if (rx_valid) begin
            if (phase_q == PH_CH0_CAP) begin
                cap_hit = 1'b1;
            end else if (phase_q == PH_CH1_CAP && armed_q) begin
                cap_hit = 1'b1;
                cap_ch  = CH1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            push[i]    = cap_hit && !par_bad && (cap_ch == tdm_ch_t'(i));
            par_set[i] = cap_hit && par_bad && (cap_ch == tdm_ch_t'(i));
            pop[i]     = !empty[i] && ready[i];
            ovf_set[i] = push[i] && full[i] && !pop[i];
        end
        phase_d = frame_sync ? 2'd0 : phase_q + 2'd1;
        armed_d = armed_q || frame_sync || (phase_q == 2'd3);
        // A new event in the clearing cycle must survive the clear
        ovf_d   = (ovf_clr ? 2'b00 : ovf_q) | ovf_set;
        par_d   = (ovf_clr ? 2'b00 : par_q) | par_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 2'd0;
            armed_q <= 1'b0;
            ovf_q   <= 2'b00;
            par_q   <= 2'b00;
        end else begin
            phase_q <= phase_d;
            armed_q <= armed_d;
            ovf_q   <= ovf_d;
            par_q   <= par_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        tdm_rx_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .wdata (rx_data),
            .pop   (pop[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    assign ovf       = ovf_q;
    assign ch0_data  = head[0];
    assign ch0_valid = !empty[0];
    assign ch1_data  = head[1];
    assign ch1_valid = !empty[1];

endmodule

// File: tb/tb_tdm_rx_demux.sv
// Randomised bench for tdm_rx_demux with a frame-level reference model and output scoreboard.
`timescale 1ns/1ps
module tb_tdm_rx_demux;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic [DW-1:0] ch0_data, ch1_data;
    logic          ch0_valid, ch1_valid;
    logic          ch0_ready = 1'b0;
    logic          ch1_ready = 1'b0;
    logic [1:0]    ovf;
    logic          ovf_clr = 1'b0;
`ifdef RX_PARITY_EN
    logic          rx_parity = 1'b0;
    logic [1:0]    par_err;
`endif

    always #5 clk = ~clk;

    tdm_rx_demux #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_sync (frame_sync),
        .ch0_data   (ch0_data),
        .ch0_valid  (ch0_valid),
        .ch0_ready  (ch0_ready),
        .ch1_data   (ch1_data),
        .ch1_valid  (ch1_valid),
        .ch1_ready  (ch1_ready),
        .ovf        (ovf),
`ifdef RX_PARITY_EN
        .rx_parity  (rx_parity),
        .par_err    (par_err),
`endif
        .ovf_clr    (ovf_clr)
    );

    int errors = 0;
    int checks = 0;

    // Written by the stimulus process only
    int            phase_m = 0;
    bit            armed_m = 1'b0;
    bit            cap_v = 1'b0;
    bit            cap_bad = 1'b0;
    int            cap_ch = 0;
    logic [DW-1:0] cap_w = '0;
    int            rst_count = 0;

    // Written by the monitor process only
    logic [DW-1:0] exp0[$];
    logic [DW-1:0] exp1[$];
    logic [1:0]    ovf_m = 2'b00;
    logic [1:0]    par_m = 2'b00;
    int            rst_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare outputs against the expected queues, then fold this cycle's capture in
    always @(negedge clk) begin
        if (rst_seen != rst_count) begin
            rst_seen = rst_count;
            exp0.delete();
            exp1.delete();
            ovf_m = 2'b00;
            par_m = 2'b00;
            check("ch0_data_after_reset", 32'(ch0_data), 32'h0);
            check("ch1_data_after_reset", 32'(ch1_data), 32'h0);
        end
        check("ch0_valid", 32'(ch0_valid), 32'(exp0.size() != 0));
        if (exp0.size() != 0) begin
            check("ch0_data", 32'(ch0_data), 32'(exp0[0]));
            if (ch0_ready) void'(exp0.pop_front());
        end
        check("ch1_valid", 32'(ch1_valid), 32'(exp1.size() != 0));
        if (exp1.size() != 0) begin
            check("ch1_data", 32'(ch1_data), 32'(exp1[0]));
            if (ch1_ready) void'(exp1.pop_front());
        end
        check("ovf", 32'(ovf), 32'(ovf_m));
`ifdef RX_PARITY_EN
        check("par_err", 32'(par_err), 32'(par_m));
`endif
        if (ovf_clr) begin
            ovf_m = 2'b00;
            par_m = 2'b00;
        end
        if (cap_v) begin
            if (cap_bad) begin
                par_m[cap_ch] = 1'b1;
            end else if (cap_ch == 0) begin
                if (exp0.size() < DEPTH) exp0.push_back(cap_w);
                else ovf_m[0] = 1'b1;
            end else begin
                if (exp1.size() < DEPTH) exp1.push_back(cap_w);
                else ovf_m[1] = 1'b1;
            end
        end
    end

    // Drive one cycle's inputs and decide from the frame rules whether a word is captured
    task automatic apply(input bit v, input logic [DW-1:0] d, input bit fs, input bit clr,
                         input bit r0, input bit r1, input bit badp);
        rx_valid   = v;
        rx_data    = d;
        frame_sync = fs;
        ovf_clr    = clr;
        ch0_ready  = r0;
        ch1_ready  = r1;
`ifdef RX_PARITY_EN
        rx_parity  = (^d) ^ badp;
        cap_bad    = badp;
`else
        cap_bad    = 1'b0;
`endif
        cap_w = d;
        cap_v = 1'b0;
        if (v && phase_m == 2) begin
            cap_v  = 1'b1;
            cap_ch = 0;
        end else if (v && phase_m == 0 && armed_m) begin
            cap_v  = 1'b1;
            cap_ch = 1;
        end
        if (fs || phase_m == 3) armed_m = 1'b1;
        phase_m = fs ? 0 : (phase_m + 1) % 4;
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit fs, input bit clr,
                         input bit r0, input bit r1, input bit badp);
        @(posedge clk);
        #1;
        apply(v, d, fs, clr, r0, r1, badp);
    endtask

    // Pulse reset between clock edges; optionally offer a word in the unarmed phase 0 after it
    task automatic do_reset(input bit word_after);
        @(posedge clk);
        #1;
        apply(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        rst_count++;
        phase_m = 0;
        armed_m = 1'b0;
        apply(word_after, 16'h2803, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n, input bit r0, input bit r1);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, r0, r1, 1'b0);
    endtask

    task automatic wait_phase(input int ph, input bit r0, input bit r1);
        while (phase_m != ph) cycle(1'b0, '0, 1'b0, 1'b0, r0, r1, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset(1'b1);

        // First ch0 word, then a ch1 word in the second frame
        wait_phase(2, 1'b0, 1'b0);
        cycle(1'b1, 16'h2933, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_phase(0, 1'b0, 1'b0);
        cycle(1'b1, 16'h2803, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b1);

        // Overflow on ch0: five words into a four-entry FIFO, drain, then clear
        for (int n = 1; n <= 5; n++) begin
            wait_phase(2, 1'b0, 1'b1);
            cycle(1'b1, 16'(n), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle(3, 1'b0, 1'b1);
        idle(6, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b1);

        // Full FIFO with simultaneous push and pop
        for (int n = 0; n < 4; n++) begin
            wait_phase(2, 1'b0, 1'b1);
            cycle(1'b1, 16'hA0 + 16'(n), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        wait_phase(2, 1'b0, 1'b1);
        cycle(1'b1, 16'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b1);
        idle(6, 1'b1, 1'b1);

        // Realign in phase 1, then a word two cycles later
        wait_phase(1, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1, 1'b1);
        cycle(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Parity: bad word on ch1 is dropped and flagged, good one delivered
        wait_phase(0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_phase(0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Reset with both FIFOs occupied
        do_reset(1'b0);
        idle(4, 1'b1, 1'b1);

        for (int seg = 0; seg < 4; seg++) begin
            int rdy;
            rdy = (seg == 0) ? 15 : (seg == 1) ? 90 : (seg == 2) ? 50 : 35;
            do_reset(1'($urandom_range(0, 1)));
            for (int i = 0; i < 500; i++) begin
                cycle($urandom_range(0, 3) != 0, 16'($urandom),
                      seg >= 2 && $urandom_range(0, 15) == 0,
                      $urandom_range(0, 24) == 0,
                      $urandom_range(0, 99) < rdy, $urandom_range(0, 99) < rdy,
                      $urandom_range(0, 7) == 0);
            end
            idle(DEPTH * 2, 1'b1, 1'b1);
        end

        idle(2, 1'b1, 1'b1);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
